// File: rtl/fir_coef_ctrl.sv
// Coefficient bank controller for the 11-tap FIR: host writes go to a shadow bank, and a
// commit copies shadow into active only once the FIR pipeline holds no samples.
module fir_coef_ctrl #(
  parameter int NB       = 9,
  parameter int NTAP     = 11,
  parameter int HOLD_MAX = 8,
  parameter int CW       = 4
) (
  input  logic               CLK,
  input  logic               RST_n,
  input  logic               CFG_WE,
  input  logic [3:0]         CFG_ADDR,
  input  logic [NB-1:0]      CFG_DATA,
  input  logic               CFG_COMMIT,
  output logic               CFG_BUSY,
  output logic               CFG_ERR,
  output logic               SWAP_DONE,
  input  logic               VIN_SRC,
  output logic               SRC_READY,
  output logic               VIN_FIR,
  input  logic               VOUT_FIR,
  output logic [NB*NTAP-1:0] B_FLAT
);
  localparam int              HW        = $clog2(HOLD_MAX + 1);
  localparam logic [3:0]      LAST_TAP  = 4'(NTAP - 1);
  localparam logic [HW-1:0]   HOLD_LAST = HW'(HOLD_MAX - 1);

  typedef enum logic [1:0] {IDLE, WAIT, DRAIN} state_t;

  state_t               state, state_nxt;
  logic [HW-1:0]        hold_cnt;
  logic [CW-1:0]        infl_cnt;
  logic signed [NB-1:0] shadow [NTAP];
  logic signed [NB-1:0] active [NTAP];
  logic                 copy;
  logic                 addr_ok;
  logic                 we_ok;
  logic                 rejected;

  // Samples inside the FIR: saturating up/down count, simultaneous in/out cancels.
  function automatic logic [CW-1:0] infl_step(input logic [CW-1:0] cnt,
                                              input logic inc, input logic dec);
    logic [CW-1:0] r;
    r = cnt;
    if (inc && !dec && cnt != '1)
      r = cnt + CW'(1);
    else if (dec && !inc && cnt != '0)
      r = cnt - CW'(1);
    return r;
  endfunction

  assign SRC_READY = (state != DRAIN);
  assign VIN_FIR   = VIN_SRC & SRC_READY & RST_n;
  assign addr_ok   = (CFG_ADDR <= LAST_TAP);
  assign we_ok     = CFG_WE & addr_ok & (state == IDLE);
  assign rejected  = (CFG_WE & (~addr_ok | CFG_BUSY)) | (CFG_COMMIT & CFG_BUSY);

  always_comb begin
    state_nxt = state;
    copy      = 1'b0;
    case (state)
      IDLE: begin
        if (CFG_COMMIT) state_nxt = WAIT;
      end
      WAIT: begin
        // A natural bubble with an empty pipeline lets the swap happen without stalling.
        if (infl_cnt == '0 && !VIN_SRC) begin
          copy      = 1'b1;
          state_nxt = IDLE;
        end else if (hold_cnt == HOLD_LAST) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (infl_cnt == '0) begin
          copy      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state     <= IDLE;
      hold_cnt  <= '0;
      infl_cnt  <= '0;
      CFG_BUSY  <= 1'b0;
      CFG_ERR   <= 1'b0;
      SWAP_DONE <= 1'b0;
    end else begin
      state     <= state_nxt;
      CFG_BUSY  <= (state_nxt != IDLE);
      CFG_ERR   <= rejected;
      SWAP_DONE <= copy;
      infl_cnt  <= infl_step(infl_cnt, VIN_FIR, VOUT_FIR);
      if (state == IDLE)
        hold_cnt <= '0;
      else if (state == WAIT)
        hold_cnt <= hold_cnt + HW'(1);
    end
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      for (int k = 0; k < NTAP; k++) begin
        shadow[k] <= '0;
        active[k] <= '0;
      end
    end else begin
      if (we_ok)
        shadow[CFG_ADDR] <= CFG_DATA;
      if (copy)
        for (int k = 0; k < NTAP; k++)
          active[k] <= shadow[k];
    end
  end

  for (genvar k = 0; k < NTAP; k++) begin : g_bus
    assign B_FLAT[NB*k +: NB] = active[k];
  end

endmodule

// File: tb/tb_fir_coef_ctrl.sv
// Bench for fir_coef_ctrl: shadow-bank reference model, scoreboard queues for swaps and
// error pulses, and a latency-3 FIR stand-in that returns VOUT_FIR.
`timescale 1ns/1ps
module tb_fir_coef_ctrl;
  localparam int NB = 9, NTAP = 11, HOLD_MAX = 8, CW = 4;
  localparam int BW = NB * NTAP;

  logic          CLK = 1'b0;
  logic          RST_n = 1'b1;
  logic          CFG_WE = 1'b0;
  logic [3:0]    CFG_ADDR = '0;
  logic [NB-1:0] CFG_DATA = '0;
  logic          CFG_COMMIT = 1'b0;
  logic          VIN_SRC = 1'b0;
  logic          VOUT_FIR;
  logic          CFG_BUSY, CFG_ERR, SWAP_DONE, SRC_READY, VIN_FIR;
  logic [BW-1:0] B_FLAT;

  logic [2:0]    fir_pipe;
  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  logic [NB-1:0] sh [NTAP];
  logic [BW-1:0] act_m;
  logic [BW-1:0] swap_q[$];
  int            err_q[$];
  bit            rand_stream = 1'b0;
  int            density = 50;

  fir_coef_ctrl #(.NB(NB), .NTAP(NTAP), .HOLD_MAX(HOLD_MAX), .CW(CW)) dut (
    .CLK(CLK), .RST_n(RST_n), .CFG_WE(CFG_WE), .CFG_ADDR(CFG_ADDR), .CFG_DATA(CFG_DATA),
    .CFG_COMMIT(CFG_COMMIT), .CFG_BUSY(CFG_BUSY), .CFG_ERR(CFG_ERR), .SWAP_DONE(SWAP_DONE),
    .VIN_SRC(VIN_SRC), .SRC_READY(SRC_READY), .VIN_FIR(VIN_FIR), .VOUT_FIR(VOUT_FIR),
    .B_FLAT(B_FLAT)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  always @(posedge CLK or negedge RST_n)
    if (!RST_n) fir_pipe <= '0;
    else        fir_pipe <= {fir_pipe[1:0], VIN_FIR};
  assign VOUT_FIR = fir_pipe[2];

  function automatic logic [BW-1:0] pack();
    logic [BW-1:0] r;
    r = '0;
    for (int k = 0; k < NTAP; k++) r = r | ({{(BW-NB){1'b0}}, sh[k]} << (NB * k));
    return r;
  endfunction

  task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK); #1;
    if (rand_stream) VIN_SRC = ($urandom_range(0, 99) < density);
  endtask

  task automatic cfg_write(input int a, input int d, input bit busy);
    CFG_WE = 1'b1; CFG_ADDR = 4'(a); CFG_DATA = NB'(d);
    if (busy || a >= NTAP) err_q.push_back(cyc + 1);
    else sh[a] = NB'(d);
    tick();
    CFG_WE = 1'b0;
  endtask

  task automatic cfg_commit(input bit busy);
    CFG_COMMIT = 1'b1;
    if (busy) err_q.push_back(cyc + 1);
    else swap_q.push_back(pack());
    tick();
    CFG_COMMIT = 1'b0;
  endtask

  task automatic cfg_write_commit(input int a, input int d);
    CFG_WE = 1'b1; CFG_COMMIT = 1'b1; CFG_ADDR = 4'(a); CFG_DATA = NB'(d);
    sh[a] = NB'(d);
    swap_q.push_back(pack());
    tick();
    CFG_WE = 1'b0; CFG_COMMIT = 1'b0;
  endtask

  task automatic wait_swap(input int bound);
    int n;
    n = 0;
    while (!SWAP_DONE && n < bound) begin tick(); n++; end
    checks++;
    if (!SWAP_DONE) begin
      errors++;
      $display("FAIL swap_timeout: no SWAP_DONE within %0d cycles, required one", bound);
    end
    tick();
  endtask

  // Swap scoreboard: every SWAP_DONE must match the oldest accepted commit.
  logic [BW-1:0] swap_exp;
  always @(negedge CLK) begin
    if (SWAP_DONE) begin
      checks++;
      if (swap_q.size() == 0) begin
        errors++;
        $display("FAIL swap_unexpected: SWAP_DONE=1 with B_FLAT=%0h, required no swap", B_FLAT);
      end else begin
        swap_exp = swap_q.pop_front();
        if (B_FLAT !== swap_exp) begin
          errors++;
          $display("FAIL swap_bflat: got %0h expected %0h", B_FLAT, swap_exp);
        end
      end
      check("swap_busy", CFG_BUSY, 0);
      check("swap_ready", SRC_READY, 1);
    end
  end

  // Error scoreboard: a pulse is required exactly in the cycles queued by the stimulus.
  bit err_exp;
  always @(negedge CLK) begin
    err_exp = (err_q.size() > 0) && (err_q[0] == cyc);
    if (CFG_ERR || err_exp) begin
      checks++;
      if (err_exp) void'(err_q.pop_front());
      if (CFG_ERR !== err_exp) begin
        errors++;
        $display("FAIL cfg_err: got %0b expected %0b at cycle %0d", CFG_ERR, err_exp, cyc);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, vouts, dones;
    bit early;
    logic [NB-1:0] tap5;

    for (int k = 0; k < NTAP; k++) sh[k] = '0;
    act_m = '0;

    // Reset state, with VIN_SRC high to show VIN_FIR is forced low.
    VIN_SRC = 1'b1;
    #1 RST_n = 1'b0;
    #2;
    check("rst_bflat", B_FLAT, 0);
    check("rst_ready", SRC_READY, 1);
    check("rst_busy", CFG_BUSY, 0);
    check("rst_err", CFG_ERR, 0);
    check("rst_done", SWAP_DONE, 0);
    check("rst_vin_fir", VIN_FIR, 0);
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    RST_n = 1'b1; VIN_SRC = 1'b0;
    tick(); tick();
    check("idle_ready", SRC_READY, 1);
    check("idle_bflat", B_FLAT, 0);
    check("idle_busy", CFG_BUSY, 0);

    // Taps 0..10 get 1..11, then a fast-path commit on an idle stream.
    for (int k = 0; k < NTAP; k++) cfg_write(k, k + 1, 1'b0);
    check("write_no_bflat", B_FLAT, act_m);
    cfg_commit(1'b0);
    check("fast_t1_bflat", B_FLAT, act_m);
    check("fast_t1_busy", CFG_BUSY, 1);
    check("fast_t1_done", SWAP_DONE, 0);
    tick();
    check("fast_t2_bflat", B_FLAT, pack());
    check("fast_t2_done", SWAP_DONE, 1);
    check("fast_t2_busy", CFG_BUSY, 0);
    act_m = pack();
    tick();
    check("fast_t3_done", SWAP_DONE, 0);

    // Rejections: bad address, write while busy, commit while busy.
    cfg_write(11, 'h0AA, 1'b0);
    tick();
    check("err_addr_bflat", B_FLAT, act_m);
    check("err_addr_busy", CFG_BUSY, 0);
    cfg_write(2, 'h020, 1'b0);
    cfg_commit(1'b0);
    cfg_write(3, 'h155, 1'b1);
    wait_swap(10);
    act_m = pack();
    cfg_commit(1'b0);
    cfg_commit(1'b1);
    wait_swap(10);
    repeat (5) tick();
    check("err_commit_busy", CFG_BUSY, 0);
    check("err_commit_bflat", B_FLAT, act_m);

    // Continuous stream: 8 WAIT cycles, then DRAIN until three samples leave the FIR.
    for (int k = 0; k < NTAP; k++) cfg_write(k, int'($urandom_range(0, 511)), 1'b0);
    VIN_SRC = 1'b1;
    repeat (6) tick();
    cfg_commit(1'b0);
    n = 0; early = 1'b0;
    while (SRC_READY && n < 30) begin
      if (B_FLAT !== act_m) early = 1'b1;
      n++; tick();
    end
    check("stream_wait_len", n, HOLD_MAX);
    vouts = 0; dones = 0;
    while (!SWAP_DONE && dones < 30) begin
      if (VOUT_FIR) vouts++;
      if (B_FLAT !== act_m || SRC_READY) early = 1'b1;
      dones++; tick();
    end
    check("stream_drain_vouts", vouts, 3);
    check("stream_no_early", early, 0);
    check("stream_done", SWAP_DONE, 1);
    check("stream_ready_back", SRC_READY, 1);
    act_m = pack();
    tick();
    VIN_SRC = 1'b0;
    repeat (5) tick();

    // Write and commit in the same idle cycle.
    cfg_write_commit(5, 'h1FD);
    wait_swap(10);
    act_m = pack();
    tap5 = B_FLAT[5*NB +: NB];
    check("same_cycle_tap5", tap5, 'h1FD);

    // Randomised writes and commits under random stream density.
    rand_stream = 1'b1;
    for (int it = 0; it < 30; it++) begin
      density = int'($urandom_range(0, 100));
      n = int'($urandom_range(0, 4));
      for (int j = 0; j < n; j++)
        cfg_write(int'($urandom_range(0, 13)), int'($urandom_range(0, 511)), 1'b0);
      if ($urandom_range(0, 1) == 1)
        cfg_write_commit(int'($urandom_range(0, NTAP - 1)), int'($urandom_range(0, 511)));
      else
        cfg_commit(1'b0);
      wait_swap(40);
      act_m = pack();
    end
    rand_stream = 1'b0;
    VIN_SRC = 1'b0;
    repeat (5) tick();

    // Reset asserted mid-DRAIN aborts the swap.
    cfg_write(7, 'h0F0, 1'b0);
    VIN_SRC = 1'b1;
    repeat (5) tick();
    cfg_commit(1'b0);
    n = 0;
    while (SRC_READY && n < 30) begin tick(); n++; end
    check("reached_drain", SRC_READY, 0);
    #2 RST_n = 1'b0;
    #1;
    swap_q.delete();
    for (int k = 0; k < NTAP; k++) sh[k] = '0;
    act_m = '0;
    check("rst_mid_bflat", B_FLAT, 0);
    check("rst_mid_ready", SRC_READY, 1);
    check("rst_mid_busy", CFG_BUSY, 0);
    check("rst_mid_vin_fir", VIN_FIR, 0);
    @(posedge CLK); #1;
    RST_n = 1'b1; VIN_SRC = 1'b0;
    dones = 0;
    repeat (15) begin tick(); if (SWAP_DONE) dones++; end
    check("rst_no_swap", dones, 0);
    check("rst_post_bflat", B_FLAT, act_m);
    check("rst_post_busy", CFG_BUSY, 0);

    check("swap_q_drained", swap_q.size(), 0);
    check("err_q_drained", err_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
